// File: rtl/pll_pkg.sv
// Shared types and default constants for the SWIPT PLL front-end blocks.
package pll_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    MEASURE    = 2'd2
  } zc_state_t;

  localparam int unsigned ZC_CNT_W      = 16;
  localparam int unsigned ZC_DEBOUNCE   = 3;
  localparam int unsigned ZC_LOCK_TOL   = 4;
  localparam int unsigned ZC_LOCK_COUNT = 8;

endpackage

// File: rtl/zero_cross_period_if.sv
// Signal bundle between the comparator source and the zero-crossing period stage.
interface zero_cross_period_if #(
  parameter int unsigned CNT_W = pll_pkg::ZC_CNT_W
);
  import pll_pkg::*;

  // Strobe semantics: period_valid, edge_pulse and timeout are single-cycle
  // valid pulses with no ready/backpressure; the consumer samples on that cycle.
  logic             swiptAlive;
  logic             ADC_comp;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             edge_pulse;
  logic             locked;
  logic             timeout;
  zc_state_t        state;
  logic             level;

  modport master (
    output swiptAlive, ADC_comp,
    input  period, period_valid, edge_pulse, locked, timeout, state, level
  );

  modport slave (
    input  swiptAlive, ADC_comp,
    output period, period_valid, edge_pulse, locked, timeout, state, level
  );

endinterface

// File: rtl/zero_cross_period_debounce.sv
// Level debouncer: the output follows the input only after DEBOUNCE consecutive
// differing samples; rise_out strobes in the cycle the debounced level goes 0->1.
module zc_debounce
  import pll_pkg::*;
#(
  parameter int unsigned DEBOUNCE = ZC_DEBOUNCE
) (
  input  logic clk,
  input  logic nrst,
  input  logic alive,
  input  logic level_in,
  output logic level_out,
  output logic rise_out
);

  logic [3:0] cnt_q, cnt_d;
  logic       level_q, level_d;
  logic       rise_q, rise_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    if (!alive) begin
      cnt_d   = '0;
      level_d = 1'b0;
    end else if (level_in != level_q) begin
      if (cnt_q + 4'd1 == DEBOUNCE[3:0]) begin
        level_d = level_in;
        rise_d  = level_in;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level_out = level_q;
  assign rise_out  = rise_q;

endmodule

// File: rtl/zero_cross_period.sv
// Rising zero-crossing qualifier and period meter with timeout and lock flag.
// Lock detection is built only when ZC_LOCK_DETECT_EN is defined; otherwise locked=0.
module zero_cross_period
  import pll_pkg::*;
#(
  parameter int unsigned CNT_W      = ZC_CNT_W,
  parameter int unsigned DEBOUNCE   = ZC_DEBOUNCE,
  parameter int unsigned LOCK_TOL   = ZC_LOCK_TOL,
  parameter int unsigned LOCK_COUNT = ZC_LOCK_COUNT
) (
  input  logic                clk,
  input  logic                nrst,
  zero_cross_period_if.slave  zc
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             rise;
  logic             level;
  zc_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             period_valid_q, period_valid_d;
  logic             edge_pulse_q, edge_pulse_d;
  logic             timeout_q, timeout_d;
  logic             locked_q;

  zc_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
    .clk       (clk),
    .nrst      (nrst),
    .alive     (zc.swiptAlive),
    .level_in  (zc.ADC_comp),
    .level_out (level),
    .rise_out  (rise)
  );

  // A qualified edge always wins over a saturated counter in the same cycle.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    edge_pulse_d   = 1'b0;
    timeout_d      = 1'b0;
    if (!zc.swiptAlive) begin
      state_d  = IDLE;
      cnt_d    = '0;
      period_d = '0;
    end else begin
      edge_pulse_d = rise;
      case (state_q)
        IDLE: state_d = WAIT_FIRST;
        WAIT_FIRST: begin
          if (rise) begin
            cnt_d   = CNT_ONE;
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_d       = cnt_q;
            period_valid_d = 1'b1;
            cnt_d          = CNT_ONE;
          end else if (cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = WAIT_FIRST;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      edge_pulse_q   <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      edge_pulse_q   <= edge_pulse_d;
      timeout_q      <= timeout_d;
    end
  end

`ifdef ZC_LOCK_DETECT_EN
  localparam logic [CNT_W:0] TOL = LOCK_TOL[CNT_W:0];
  localparam logic [7:0]     LC  = LOCK_COUNT[7:0];

  logic [CNT_W-1:0] prev_q, prev_d;
  logic             have_prev_q, have_prev_d;
  logic [7:0]       match_q, match_d;
  logic             locked_d;
  logic [CNT_W:0]   diff;

  // Evaluated the cycle after period_valid, so locked trails it by one cycle.
  always_comb begin
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    match_d     = match_q;
    locked_d    = locked_q;
    diff        = (period_q >= prev_q) ? ({1'b0, period_q} - {1'b0, prev_q})
                                       : ({1'b0, prev_q} - {1'b0, period_q});
    if (!zc.swiptAlive || timeout_d) begin
      prev_d      = '0;
      have_prev_d = 1'b0;
      match_d     = '0;
      locked_d    = 1'b0;
    end else if (period_valid_q) begin
      prev_d      = period_q;
      have_prev_d = 1'b1;
      if (have_prev_q) begin
        if (diff <= TOL) begin
          if (match_q != LC) match_d = match_q + 8'd1;
          locked_d = (match_d == LC);
        end else begin
          match_d  = '0;
          locked_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      match_q     <= '0;
      locked_q    <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      match_q     <= match_d;
      locked_q    <= locked_d;
    end
  end
`else
  assign locked_q = 1'b0;
`endif

  assign zc.period       = period_q;
  assign zc.period_valid = period_valid_q;
  assign zc.edge_pulse   = edge_pulse_q;
  assign zc.timeout      = timeout_q;
  assign zc.locked       = locked_q;
  assign zc.state        = state_q;
  assign zc.level        = level;

endmodule

// File: tb/tb_zero_cross_period.sv
// Directed bench for zero_cross_period (CNT_W=8) with immediate-assertion checks.
module tb_zero_cross_period;
  import pll_pkg::*;

  localparam int unsigned CNT_W = 8;
`ifdef ZC_LOCK_DETECT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk;
  logic nrst;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   n_edge = 0;
  logic [CNT_W-1:0] got_q[$];
  logic [CNT_W-1:0] exp_q[$];
  int   vcyc_q[$];

  zero_cross_period_if #(.CNT_W(CNT_W)) zc_if ();

  zero_cross_period #(
    .CNT_W(CNT_W), .DEBOUNCE(3), .LOCK_TOL(4), .LOCK_COUNT(8)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .zc   (zc_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // output monitor sampled on the falling edge
  always @(negedge clk) begin
    if (zc_if.edge_pulse === 1'b1) n_edge = n_edge + 1;
    if (zc_if.period_valid === 1'b1) begin
      got_q.push_back(zc_if.period);
      vcyc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic lvl, input int n);
    zc_if.ADC_comp = lvl;
    repeat (n) tick();
  endtask

  task automatic wave(input int hi, input int lo);
    hold(1'b1, hi);
    hold(1'b0, lo);
  endtask

  // Rise that closes a measured interval: checks period and the following lock state.
  task automatic measured_rise(input int p_exp, input bit lock_exp, input int hi, input int lo,
                               input string tag);
    hold(1'b1, 4);
    check({tag, "_valid"}, zc_if.period_valid, 1);
    check({tag, "_period"}, zc_if.period, p_exp);
    tick();
    check({tag, "_locked"}, zc_if.locked, lock_exp & LOCK_EN);
    hold(1'b1, hi - 5);
    hold(1'b0, lo);
  endtask

  task automatic clear_scoreboard();
    got_q.delete();
    exp_q.delete();
    vcyc_q.delete();
    n_edge = 0;
  endtask

  task automatic compare_scoreboard(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_period"}, got_q[i], exp_q[i]);
    for (int i = 1; i < vcyc_q.size(); i++)
      check({tag, "_spacing"}, vcyc_q[i] - vcyc_q[i-1], 100);
  endtask

  int lock_p[10] = '{100, 102, 99, 101, 100, 102, 99, 101, 100, 110};

  initial begin
    nrst = 1'b0;
    zc_if.swiptAlive = 1'b0;
    zc_if.ADC_comp = 1'b0;
    repeat (3) tick();
    check("rst_period", zc_if.period, 0);
    check("rst_valid", zc_if.period_valid, 0);
    check("rst_edge", zc_if.edge_pulse, 0);
    check("rst_locked", zc_if.locked, 0);
    check("rst_timeout", zc_if.timeout, 0);
    check("rst_state", zc_if.state, IDLE);

    nrst = 1'b1;
    zc_if.swiptAlive = 1'b1;
    tick();
    check("idle_to_wait", zc_if.state, WAIT_FIRST);

    // square wave 50/50: first edge latency and no valid, then period 100
    clear_scoreboard();
    hold(1'b1, 3);
    check("first_edge_early", zc_if.edge_pulse, 0);
    tick();
    check("first_edge", zc_if.edge_pulse, 1);
    check("first_no_valid", zc_if.period_valid, 0);
    check("first_state", zc_if.state, MEASURE);
    hold(1'b1, 46);
    hold(1'b0, 50);
    repeat (3) wave(50, 50);
    repeat (3) exp_q.push_back(8'd100);
    compare_scoreboard("square");
    check("square_edges", n_edge, 4);

    // glitches shorter than the debounce depth
    clear_scoreboard();
    repeat (2) begin
      hold(1'b1, 20); hold(1'b0, 2); hold(1'b1, 28);
      hold(1'b0, 20); hold(1'b1, 2); hold(1'b0, 28);
    end
    repeat (2) exp_q.push_back(8'd100);
    compare_scoreboard("glitch");
    check("glitch_edges", n_edge, 2);
    check("glitch_period_hold", zc_if.period, 100);

    // one-cycle swiptAlive drop mid-MEASURE
    hold(1'b0, 10);
    zc_if.swiptAlive = 1'b0;
    tick();
    check("drop_period", zc_if.period, 0);
    check("drop_valid", zc_if.period_valid, 0);
    check("drop_edge", zc_if.edge_pulse, 0);
    check("drop_locked", zc_if.locked, 0);
    check("drop_timeout", zc_if.timeout, 0);
    check("drop_state", zc_if.state, IDLE);
    zc_if.swiptAlive = 1'b1;
    hold(1'b1, 4);
    check("reen_edge", zc_if.edge_pulse, 1);
    check("reen_no_valid", zc_if.period_valid, 0);
    hold(1'b1, lock_p[0] / 2 - 4);
    hold(1'b0, lock_p[0] - lock_p[0] / 2);

    // lock sequence: locked after the 9th valid period, lost on 110
    for (int i = 1; i < 10; i++)
      measured_rise(lock_p[i-1], (i == 9), lock_p[i] / 2, lock_p[i] - lock_p[i] / 2,
                    $sformatf("lock%0d", i));
    hold(1'b1, 4);
    check("unlock_valid", zc_if.period_valid, 1);
    check("unlock_period", zc_if.period, 110);
    tick();
    check("unlock_locked", zc_if.locked, 0);

    // input stuck high: timeout 255 cycles after the last edge_pulse
    repeat (253) tick();
    check("timeout_early", zc_if.timeout, 0);
    tick();
    check("timeout_pulse", zc_if.timeout, 1);
    check("timeout_locked", zc_if.locked, 0);
    check("timeout_state", zc_if.state, WAIT_FIRST);
    check("timeout_period_hold", zc_if.period, 110);
    tick();
    check("timeout_one_cycle", zc_if.timeout, 0);

    // recovery: two edges restore period_valid
    hold(1'b0, 10);
    hold(1'b1, 4);
    check("recov_edge", zc_if.edge_pulse, 1);
    check("recov_no_valid", zc_if.period_valid, 0);
    hold(1'b1, 46);
    hold(1'b0, 50);
    hold(1'b1, 4);
    check("recov_valid", zc_if.period_valid, 1);
    check("recov_period", zc_if.period, 100);

    // asynchronous reset between clock edges
    #2;
    nrst = 1'b0;
    #1;
    check("async_period", zc_if.period, 0);
    check("async_valid", zc_if.period_valid, 0);
    check("async_edge", zc_if.edge_pulse, 0);
    check("async_state", zc_if.state, IDLE);
    #1;
    nrst = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/zero_cross_period.md
# zero_cross_period

Edge-qualification and period-measurement stage that consumes the 1-bit `ADC_comp` comparator output of the SWIPT PLL front end. It debounces the comparator level, detects rising zero-crossings, and measures the interval between consecutive crossings in `clk` cycles. It also flags frequency lock and signal loss. Its `period` output feeds the PLL loop filter and NCO control downstream.

## Interface
- `CNT_W`, 16: width of the period counter and of the `period` output.
- `DEBOUNCE`, 3: consecutive identical samples required before the debounced level changes; range 1–15.
- `LOCK_TOL`, 4: maximum |period − previous period| in cycles that counts as a match.
- `LOCK_COUNT`, 8: consecutive matches required to assert `locked`; range 1–255.

Ports:
- `clk` in 1: system clock; all logic on the rising edge.
- `nrst` in 1: asynchronous active-low reset.
- `swiptAlive` in 1: link-alive enable; low means synchronous clear of all state.
- `ADC_comp` in 1: comparator level, already registered in the `clk` domain, so no synchronizer is used.
- `period` out `CNT_W`: last measured rising-to-rising interval, in cycles.
- `period_valid` out 1: one-cycle strobe when `period` updates.
- `edge_pulse` out 1: one-cycle strobe per qualified rising crossing.
- `locked` out 1: frequency-lock flag.
- `timeout` out 1: one-cycle strobe when no crossing occurs within 2^`CNT_W`−1 cycles.

## Operation
- Reset (`nrst`=0) or `swiptAlive`=0 clears all state:
  - `period`=0, `period_valid`=0, `edge_pulse`=0, `locked`=0, `timeout`=0.
  - Debounced level = 0, debounce counter = 0, FSM = IDLE.
- Debounce:
  - Counter increments while `ADC_comp` ≠ debounced level, and clears when they are equal.
  - When the counter reaches `DEBOUNCE`, the debounced level takes `ADC_comp` and the counter clears.
- Edge: `edge_pulse`=1 for one cycle after the debounced level goes 0→1. Falling transitions are ignored.
- Period counter `cnt`:
  - Increments every cycle in MEASURE and saturates at 2^`CNT_W`−1.
  - On an edge: `period` ← `cnt`, `cnt` ← 1.
- FSM states:
  - IDLE: entered on reset or when `swiptAlive`=0. Moves to WAIT_FIRST on the first cycle with `swiptAlive`=1.
  - WAIT_FIRST: on an edge, `cnt` ← 1 and the FSM moves to MEASURE. No `period_valid` is issued.
  - MEASURE, edge: `period_valid`=1 with the new `period`; the FSM stays in MEASURE.
  - MEASURE, `cnt` saturated: `timeout` pulses, `locked` ← 0, match count ← 0, and the FSM moves to WAIT_FIRST. `period` holds its last value.
- Lock detection:
  - On each `period_valid`, compare the new period with the previous valid period using an unsigned absolute difference computed at `CNT_W`+1 bits.
  - Difference ≤ `LOCK_TOL`: match count increments, saturating at `LOCK_COUNT`. `locked`=1 once the count equals `LOCK_COUNT`.
  - Otherwise: match count ← 0 and `locked` ← 0 in the same cycle.
  - The first `period_valid` after entering MEASURE only loads the previous-period register and does not count as a match.
- Simultaneous events:
  - An edge in the same cycle as saturation is treated as an edge; no timeout.
  - `swiptAlive` falling overrides everything.

## Timing
- Debounced level changes at the `DEBOUNCE`-th consecutive differing sample.
- `edge_pulse` and `period_valid` are asserted together, one cycle after the debounced rise.
- Input rise to `edge_pulse` is therefore `DEBOUNCE`+1 cycles. The latency is constant, so the measured period is unaffected by it.
- `locked` updates in the cycle after `period_valid`.
- A clean square wave of period P yields `period`=P exactly.
- All outputs are registered.

## Configuration
- Macro `ZC_LOCK_DETECT_EN`.
- Defined: lock detection is built as described above.
- Undefined: the previous-period register, the match counter and the comparator are removed, and `locked` is tied to 0. All other behaviour is identical.

## Structure
- Shared package `pll_pkg`:
  - FSM state enum `zc_state_t` {IDLE, WAIT_FIRST, MEASURE}.
  - Default constants for `CNT_W`, `DEBOUNCE`, `LOCK_TOL` and `LOCK_COUNT`.
- One sub-module, `zc_debounce`:
  - Inputs: level in, `swiptAlive` clear.
  - Outputs: debounced level and rising-edge strobe.
- Period counter, FSM and lock logic live in the top module.

## Test plan
Defaults apply unless a scenario states otherwise.
- Square wave 50 high / 50 low, `swiptAlive`=1: first edge gives no `period_valid`; every later edge gives `period`=100 with `period_valid`, spaced 100 cycles apart.
- 2-cycle low glitch inside a high phase, plus a 2-cycle high glitch inside a low phase: no `edge_pulse`; `period` stays 100.
- Periods 100, 102, 99, 101, …, 9 valid periods in total: `locked`=1 after the 9th valid period. Next period 110: `locked`=0 in the following cycle.
- Stop the input after lock, with `CNT_W`=8: `timeout` pulses 255 cycles after the last edge, `locked`=0, FSM returns to WAIT_FIRST. The next two edges restore `period_valid`.
- Drop `swiptAlive` for one cycle mid-MEASURE: all outputs are 0 the next cycle. After re-enable, the first edge gives no `period_valid`.
- Assert `nrst`=0 asynchronously between clock edges: outputs clear immediately, without waiting for a `clk` edge.
